pattern_merge_pipe: RTL and testbench

//  Parametrised, handshaked successor to the fixed merged-pattern netlists.

---
 rtl/pattern_merge_pipe.sv | 103 ++++++++++
 tb/tb_pattern_merge_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_merge_pipe.sv
// pattern_merge_pipe: handshaked lane-gate pipeline with flush, safe cfg reload and transfer counter.
// Optional out_parity port when PMP_PARITY_EN is defined.
module pattern_merge_pipe #(
  parameter int WIDTH = 4,
  parameter int STAGES = 2,
  parameter int CNT_W = 8
) (
  input  logic                  blif_clk_net,
  input  logic                  blif_reset_net,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  flush,
  input  logic [2*STAGES-1:0]   cfg_mode,
  input  logic                  cfg_load,
  output logic                  cfg_busy,
  output logic [CNT_W-1:0]      out_count
`ifdef PMP_PARITY_EN
  ,
  output logic                  out_parity
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [2*STAGES-1:0] cfg, shadow;
  logic [STAGES-1:0] v, adv, vin;
  logic [STAGES:0] vcat;
  logic [WIDTH-1:0] d [STAGES];
  logic [WIDTH-1:0] nxt [STAGES];
  logic [1:0] cfg0;
  logic take;

  function automatic logic [WIDTH-1:0] gate(input logic [1:0] m, input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = {x[0], x[WIDTH-1:1]};
    return m == 2'b00 ? ~(x | r) : m == 2'b01 ? ~(x & r) : m == 2'b10 ? x & r : x | r;
  endfunction

  // a word entering while an IDLE reload is adopted must see the new cfg in stage 0 too
  assign cfg0 = (state == IDLE && cfg_load) ? cfg_mode[1:0] : cfg[1:0];
  assign in_ready = adv[0] && state != DRAIN;
  assign take = in_valid && in_ready;
  assign vcat = {v, take};
  assign vin = vcat[STAGES-1:0];
  assign out_data = d[STAGES-1];
  assign out_valid = v[STAGES-1];
  assign cfg_busy = state == DRAIN;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    assign adv[s] = out_ready || !(&v[STAGES-1:s]);
    if (s == 0) begin : g_first
      assign nxt[s] = gate(cfg0, in_data);
    end else begin : g_rest
      assign nxt[s] = gate(cfg[2*s+:2], d[s-1]);
    end
  end

  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      state <= IDLE;
      cfg <= '0;
      shadow <= '0;
      v <= '0;
      out_count <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= adv[i] ? nxt[i] : d[i];
        v[i] <= flush ? 1'b0 : adv[i] ? vin[i] : v[i];
      end
      if (out_valid && out_ready) out_count <= out_count + 1'b1;
      case (state)
        IDLE: begin
          if (cfg_load) cfg <= cfg_mode;
          if (take && !flush) state <= RUN;
        end
        RUN: begin
          if (cfg_load) begin
            shadow <= cfg_mode;
            state <= DRAIN;
          end else if (v == '0 && !take) state <= IDLE;
        end
        DRAIN: begin
          if (v == '0) begin
            cfg <= shadow;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PMP_PARITY_EN
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) out_parity <= 1'b0;
    else if (adv[STAGES-1]) out_parity <= ^nxt[STAGES-1];
  end
`endif
endmodule

// File: tb/tb_pattern_merge_pipe.sv
// tb_pattern_merge_pipe: table vectors plus scoreboard-checked sequences for pattern_merge_pipe.
module tb_pattern_merge_pipe;
  logic clk = 0, rst = 1;
  logic [3:0] in_data = '0, out_data, cfg_mode = '0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1, flush = 0, cfg_load = 0, cfg_busy;
  logic [7:0] out_count;
`ifdef PMP_PARITY_EN
  logic out_parity;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [3:0] exp_q[$];
  logic [3:0] mcfg = 4'b0100;
  logic [7:0] mcount = 0;

  pattern_merge_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut (
    .blif_clk_net(clk), .blif_reset_net(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .cfg_mode(cfg_mode), .cfg_load(cfg_load), .cfg_busy(cfg_busy),
    .out_count(out_count)
`ifdef PMP_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] din; logic [3:0] mode; logic [3:0] want; } vec_t;
  vec_t vecs[6];

  function automatic logic [3:0] mgate(input logic [1:0] m, input logic [3:0] x);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) begin
      logic a, b;
      a = x[i];
      b = x[(i + 1) % 4];
      case (m)
        2'b00: y[i] = !(a || b);
        2'b01: y[i] = !(a && b);
        2'b10: y[i] = a && b;
        default: y[i] = a || b;
      endcase
    end
    return y;
  endfunction

  function automatic logic [3:0] model(input logic [3:0] x, input logic [3:0] c);
    return mgate(c[3:2], mgate(c[1:0], x));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // scoreboard: push the model result on every accepted word, pop on every output transfer
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_count", out_count, mcount);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) bad("unexpected_output");
        else chk("out_data", out_data, exp_q.pop_front());
        mcount++;
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_data, mcfg));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] x);
    in_data = x;
    in_valid = 1;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
      if (i == 50) bad("send_timeout");
    end
    step();
    in_valid = 0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    bad("out_valid_timeout");
  endtask

  task automatic drain();
    for (int i = 0; i <= 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (i == 2000) bad("drain_timeout");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [3:0] held;
    vecs[0] = '{4'b0101, 4'b0100, 4'b1111};
    vecs[1] = '{4'b0101, 4'b1110, 4'b0000};
    vecs[2] = '{4'b0011, 4'b1110, 4'b1001};
    vecs[3] = '{4'b0001, 4'b0000, 4'b1000};
    vecs[4] = '{4'b0110, 4'b1001, 4'b1100};
    vecs[5] = '{4'b1000, 4'b0111, 4'b1011};

    // reset and idle state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    rst = 0;

    // IDLE reload is immediate and never raises busy
    cfg_mode = 4'b0100;
    cfg_load = 1;
    @(negedge clk);
    step();
    cfg_load = 0;
    @(negedge clk);
    chk("idle_load_busy", cfg_busy, 0);

    // single word latency
    step();
    send(4'b0101);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("latency", n, 2);
    chk("single_data", out_data, 4'b1111);
    drain();
    chk("single_count", out_count, 1);

    // back-to-back, no bubble
    step();
    send(4'b0000);
    send(4'b0101);
    wait_out();
    chk("b2b_first", out_data, 4'b0000);
    @(negedge clk);
    chk("b2b_no_bubble", out_valid, 1);
    chk("b2b_second", out_data, 4'b1111);
    drain();

    // backpressure: fill then stall 5 clocks
    step();
    out_ready = 0;
    send(4'b0011);
    send(4'b0001);
    in_data = 4'b1000;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_hold", out_data, model(4'b0011, mcfg));
    end
    step();
    out_ready = 1;
    send(4'b1000);
    drain();

    // table vectors, each with its own cfg adopted in IDLE alongside the word
    foreach (vecs[k]) begin
      step();
      cfg_mode = vecs[k].mode;
      mcfg = vecs[k].mode;
      cfg_load = 1;
      in_data = vecs[k].din;
      in_valid = 1;
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1);
      step();
      cfg_load = 0;
      in_valid = 0;
      wait_out();
      chk("vec_out", out_data, vecs[k].want);
      drain();
    end

    // restore stage0 NOR, stage1 NAND
    step();
    cfg_mode = 4'b0100;
    mcfg = 4'b0100;
    cfg_load = 1;
    step();
    cfg_load = 0;

    // reload while two words in flight; a second load during DRAIN is ignored
    out_ready = 0;
    send(4'b0101);
    send(4'b0000);
    cfg_mode = 4'b1110;
    cfg_load = 1;
    step();
    cfg_mode = 4'b0000;
    @(negedge clk);
    chk("drain_busy", cfg_busy, 1);
    chk("drain_in_ready", in_ready, 0);
    step();
    cfg_load = 0;
    out_ready = 1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (!cfg_busy) break;
      if (i == 20) bad("busy_timeout");
    end
    chk("drained_before_cfg", exp_q.size(), 0);
    mcfg = 4'b1110;
    step();
    send(4'b0101);
    wait_out();
    chk("new_cfg_out", out_data, 4'b0000);
    drain();

    // flush with full pipe and pending input; the same-cycle output still counts
    step();
    out_ready = 0;
    send(4'b0011);
    send(4'b0110);
    in_data = 4'b1111;
    in_valid = 1;
    flush = 1;
    out_ready = 1;
    step();
    flush = 0;
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_empty", out_valid, 0);
    end

    // wrap the transfer counter
    drain();
    step();
    n = 255 - int'(mcount);
    for (int i = 0; i < n; i++) send(4'(i));
    drain();
    chk("count_255", out_count, 255);
    step();
    send(4'b1010);
    drain();
    chk("count_wrap", out_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
